// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package divider_pkg;

  localparam int DW = 32;
  localparam int NW = 2 * DW;
  localparam int CW = $clog2(DW);

  // Field positions of the packed {remainder, quotient} result word.
  localparam int RES_Q_LSB = 0;
  localparam int RES_R_LSB = 32;

  localparam logic [NW-1:0] DIV0_RESULT = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [NW-1:0] OVF_RESULT  = 64'h0000_0000_0000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FIXUP  = 2'd2
  } state_e;

endpackage

// File: rtl/divider_restoring_div_trial_sub.sv
// Trial subtraction for one restoring step: P (33b) minus zero-extended divisor.
// The low 32 bits go through a ripple chain of Add_rca_1 cells fed with the
// inverted divisor and carry-in 1. P[32] set means P already exceeds any 32-bit
// divisor, so the result is non-negative regardless of the low carry.

// One-bit full adder cell used to build the ripple chain.
module Add_rca_1 (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module div_trial_sub
  import divider_pkg::*;
(
  input  logic [DW:0]   p_i,
  input  logic [DW-1:0] divisor_i,
  output logic [DW-1:0] diff_o,
  output logic          nonneg_o
);

  logic [DW:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < DW; i++) begin : g_rca
    Add_rca_1 u_fa (
      .a_i (p_i[i]),
      .b_i (~divisor_i[i]),
      .c_i (carry[i]),
      .s_o (diff_o[i]),
      .c_o (carry[i+1])
    );
  end

  // A carry out of the low chain means no borrow: P[31:0] >= divisor.
  assign nonneg_o = p_i[DW] | carry[DW];

endmodule

// File: rtl/divider_restoring.sv
// Sequential signed restoring divider, 64b dividend / 32b divisor, one quotient
// bit per clock. result = {remainder, quotient}, truncating semantics with the
// remainder taking the dividend's sign.
// Optional build macro DIVIDER_UNSIGNED_MODE_EN adds the is_signed input; when it
// is low at accept the operands are treated as unsigned.
// Handshake: start is sampled only in IDLE; valid is a one-cycle pulse and
// qualifies result/div_by_zero/overflow, which then hold until the next valid.
module divider_restoring
  import divider_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [31:0]   opera1,
  input  logic [63:0]   opera2,
`ifdef DIVIDER_UNSIGNED_MODE_EN
  input  logic          is_signed,
`endif
  output logic [63:0]   result,
  output logic          valid,
  output logic          busy,
  output logic          div_by_zero,
  output logic          overflow
);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW:0]     p_q, p_d;        // partial remainder
  logic [DW-1:0]   quo_q, quo_d;    // low dividend bits shifting out, quotient bits shifting in
  logic [DW-1:0]   dvs_q, dvs_d;    // divisor magnitude
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic            sgn_q, sgn_d;
  logic            dz_q, dz_d;      // divide-by-zero found at accept
  logic            eovf_q, eovf_d;  // early overflow found at accept
  logic [NW-1:0]   result_q, result_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            div0_q, div0_d;
  logic            ovf_q, ovf_d;

  logic            signed_mode;
  logic            a_neg, b_neg;
  logic [NW-1:0]   dvd_mag;
  logic [DW-1:0]   dvs_mag;
  logic [DW:0]     p_shift;
  logic [DW-1:0]   trial_diff;
  logic            trial_nonneg;
  logic [DW-1:0]   q_val, r_val;
  logic            range_ovf;

`ifdef DIVIDER_UNSIGNED_MODE_EN
  assign signed_mode = is_signed;
`else
  assign signed_mode = 1'b1;
`endif

  // Operand magnitudes, only meaningful at the accept cycle.
  assign a_neg   = signed_mode & opera2[NW-1];
  assign b_neg   = signed_mode & opera1[DW-1];
  assign dvd_mag = a_neg ? -opera2 : opera2;
  assign dvs_mag = b_neg ? -opera1 : opera1;

  assign p_shift = {p_q[DW-1:0], quo_q[DW-1]};

  div_trial_sub u_trial (
    .p_i       (p_shift),
    .divisor_i (dvs_q),
    .diff_o    (trial_diff),
    .nonneg_o  (trial_nonneg)
  );

  assign q_val     = q_neg_q ? -quo_q : quo_q;
  assign r_val     = r_neg_q ? -p_q[DW-1:0] : p_q[DW-1:0];
  assign range_ovf = sgn_q & (q_neg_q ? (quo_q > 32'h8000_0000) : (quo_q > 32'h7FFF_FFFF));

  // State, datapath and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      p_q      <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      sgn_q    <= 1'b0;
      dz_q     <= 1'b0;
      eovf_q   <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      sgn_q    <= sgn_d;
      dz_q     <= dz_d;
      eovf_q   <= eovf_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state, iteration and result formation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    sgn_d    = sgn_q;
    dz_d     = dz_q;
    eovf_d   = eovf_q;
    result_d = result_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          busy_d  = 1'b1;
          cnt_d   = '0;
          p_d     = {1'b0, dvd_mag[NW-1:DW]};
          quo_d   = dvd_mag[DW-1:0];
          dvs_d   = dvs_mag;
          q_neg_d = a_neg ^ b_neg;
          r_neg_d = a_neg;
          sgn_d   = signed_mode;
          dz_d    = (dvs_mag == '0);
          eovf_d  = (dvd_mag[NW-1:DW] >= dvs_mag);
          state_d = ((dvs_mag == '0) || (dvd_mag[NW-1:DW] >= dvs_mag)) ? FIXUP : DIVIDE;
        end
      end
      DIVIDE: begin
        p_d   = trial_nonneg ? {1'b0, trial_diff} : p_shift;
        quo_d = {quo_q[DW-2:0], trial_nonneg};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DW - 1)) begin
          cnt_d   = '0;
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        valid_d = 1'b1;
        state_d = IDLE;
        if (dz_q) begin
          result_d = DIV0_RESULT;
          div0_d   = 1'b1;
          ovf_d    = 1'b0;
        end else if (eovf_q || range_ovf) begin
          result_d = OVF_RESULT;
          div0_d   = 1'b0;
          ovf_d    = 1'b1;
        end else begin
          result_d[RES_Q_LSB +: DW] = q_val;
          result_d[RES_R_LSB +: DW] = r_val;
          div0_d   = 1'b0;
          ovf_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign result      = result_q;
  assign valid       = valid_q;
  assign busy        = busy_q;
  assign div_by_zero = div0_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_divider_restoring.sv
// Directed bench for divider_restoring: signs, divide-by-zero, overflow bounds,
// mid-operation reset and back-to-back starts.
module tb_divider_restoring;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] opera1 = '0;
  logic [63:0] opera2 = '0;
  logic [63:0] result;
  logic        valid, busy, div_by_zero, overflow;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [63:0] exp_q[$];

  // Clock and DUT.
  always #5 clock = ~clock;

  divider_restoring dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .opera1      (opera1),
    .opera2      (opera2),
`ifdef DIVIDER_UNSIGNED_MODE_EN
    .is_signed   (1'b1),
`endif
    .result      (result),
    .valid       (valid),
    .busy        (busy),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  // Driver: launch one operation and collect its completion.
  // lat counts rising edges from the accept edge (1) to the edge after which valid is seen.
  task automatic run_op(input logic [63:0] dvd, input logic [31:0] dvs,
                        output int lat, output logic [63:0] res,
                        output logic dz, output logic ovf,
                        output logic b_first, output logic b_valid,
                        output logic b_after, output logic v_after, output logic got);
    @(negedge clock);
    opera2 = dvd; opera1 = dvs; start = 1'b1;
    @(posedge clock);
    lat = 1;
    @(negedge clock);
    start = 1'b0;
    opera2 = ~dvd; opera1 = ~dvs;
    b_first = busy; got = 1'b0; res = '0; dz = 1'b0; ovf = 1'b0; b_valid = 1'b0;
    while (!got && lat < 100) begin
      if (valid) begin
        got = 1'b1; res = result; dz = div_by_zero; ovf = overflow; b_valid = busy;
      end else begin
        @(posedge clock); lat++; @(negedge clock);
      end
    end
    @(posedge clock); @(negedge clock);
    b_after = busy; v_after = valid;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    tests_run++;
    if ({result, valid, busy, div_by_zero, overflow} !== 68'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs got %h/%b%b%b%b required 0", result, valid, busy, div_by_zero, overflow);
    end
    // start together with reset: reset wins
    opera2 = 64'd100; opera1 = 32'd7; start = 1'b1;
    @(posedge clock); @(negedge clock);
    start = 1'b0; reset = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_start_busy got %b required 0", busy);
    end
    begin
      int nv = 0;
      repeat (40) begin @(posedge clock); @(negedge clock); if (valid) nv++; end
      tests_run++;
      if (nv != 0) begin
        tests_failed++;
        $display("FAIL reset_start_valid got %0d valids required 0", nv);
      end
    end
  endtask

  task automatic test_signed_basic();
    logic [63:0] dvd_t [6] = '{64'd100, 64'hFFFF_FFFF_FFFF_FF9C, 64'd100,
                               64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'h0000_0000_FFFF_FFFF};
    logic [31:0] dvs_t [6] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd2};
    logic [63:0] exp_t [6] = '{64'h0000_0002_0000_000E, 64'hFFFF_FFFE_FFFF_FFF2,
                               64'h0000_0002_FFFF_FFF2, 64'hFFFF_FFFE_0000_000E,
                               64'h0000_0007_0000_0000, 64'h0000_0001_7FFF_FFFF};
    int lat; logic [63:0] res; logic dz, ovf, bf, bv, ba, va, got;
    for (int i = 0; i < 6; i++) begin
      run_op(dvd_t[i], dvs_t[i], lat, res, dz, ovf, bf, bv, ba, va, got);
      tests_run++;
      if (!got || lat != 34) begin
        tests_failed++;
        $display("FAIL basic[%0d] latency got %0d (seen %b) required 34", i, lat, got);
      end
      tests_run++;
      if (res !== exp_t[i] || dz !== 1'b0 || ovf !== 1'b0) begin
        tests_failed++;
        $display("FAIL basic[%0d] result got %h dz %b ovf %b required %h dz 0 ovf 0", i, res, dz, ovf, exp_t[i]);
      end
      tests_run++;
      if ({bf, bv, ba, va} !== 4'b1100) begin
        tests_failed++;
        $display("FAIL basic[%0d] busy/valid shape got %b%b%b%b required 1100", i, bf, bv, ba, va);
      end
      tests_run++;
      if (result !== exp_t[i]) begin
        tests_failed++;
        $display("FAIL basic[%0d] result_hold got %h required %h", i, result, exp_t[i]);
      end
    end
  endtask

  task automatic test_div_by_zero();
    logic [63:0] dvd_t [2] = '{64'd123, 64'h0000_0100_0000_0000};
    int lat; logic [63:0] res; logic dz, ovf, bf, bv, ba, va, got;
    for (int i = 0; i < 2; i++) begin
      run_op(dvd_t[i], 32'd0, lat, res, dz, ovf, bf, bv, ba, va, got);
      tests_run++;
      if (!got || lat != 2) begin
        tests_failed++;
        $display("FAIL div0[%0d] latency got %0d (seen %b) required 2", i, lat, got);
      end
      tests_run++;
      if (res !== 64'hFFFF_FFFF_FFFF_FFFF || dz !== 1'b1 || ovf !== 1'b0) begin
        tests_failed++;
        $display("FAIL div0[%0d] result got %h dz %b ovf %b required all ones dz 1 ovf 0", i, res, dz, ovf);
      end
      tests_run++;
      if ({bf, bv, ba, va} !== 4'b1100) begin
        tests_failed++;
        $display("FAIL div0[%0d] busy/valid shape got %b%b%b%b required 1100", i, bf, bv, ba, va);
      end
    end
  endtask

  task automatic test_overflow();
    logic [63:0] dvd_t [4] = '{64'h0000_0100_0000_0000, 64'h0000_0000_8000_0000,
                               64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000};
    logic [31:0] dvs_t [4] = '{32'd1, 32'd1, 32'd1, 32'hFFFF_FFFF};
    int          lat_t [4] = '{2, 34, 34, 34};
    logic        ovf_t [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [63:0] exp_t [4] = '{64'd0, 64'd0, 64'h0000_0000_8000_0000, 64'd0};
    int lat; logic [63:0] res; logic dz, ovf, bf, bv, ba, va, got;
    for (int i = 0; i < 4; i++) begin
      run_op(dvd_t[i], dvs_t[i], lat, res, dz, ovf, bf, bv, ba, va, got);
      tests_run++;
      if (!got || lat != lat_t[i]) begin
        tests_failed++;
        $display("FAIL ovf[%0d] latency got %0d (seen %b) required %0d", i, lat, got, lat_t[i]);
      end
      tests_run++;
      if (res !== exp_t[i] || ovf !== ovf_t[i] || dz !== 1'b0) begin
        tests_failed++;
        $display("FAIL ovf[%0d] result got %h ovf %b dz %b required %h ovf %b dz 0", i, res, ovf, dz, exp_t[i], ovf_t[i]);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int nv = 0;
    int lat; logic [63:0] res; logic dz, ovf, bf, bv, ba, va, got;
    @(negedge clock);
    opera2 = 64'd100; opera1 = 32'd7; start = 1'b1;
    @(posedge clock); @(negedge clock);
    start = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    reset = 1'b0;
    tests_run++;
    if ({result, valid, busy, div_by_zero, overflow} !== 68'd0) begin
      tests_failed++;
      $display("FAIL midreset_outputs got %h/%b%b%b%b required 0", result, valid, busy, div_by_zero, overflow);
    end
    repeat (40) begin @(posedge clock); @(negedge clock); if (valid) nv++; end
    tests_run++;
    if (nv != 0) begin
      tests_failed++;
      $display("FAIL midreset_valid got %0d valids required 0", nv);
    end
    run_op(64'd100, 32'd7, lat, res, dz, ovf, bf, bv, ba, va, got);
    tests_run++;
    if (!got || lat != 34 || res !== 64'h0000_0002_0000_000E) begin
      tests_failed++;
      $display("FAIL midreset_rerun got %h lat %0d (seen %b) required 000000020000000e lat 34", res, lat, got);
    end
  endtask

  task automatic test_back_to_back();
    int edge_n = 1;
    int nv = 0;
    int v_edge [2] = '{0, 0};
    logic [63:0] exp_v;
    exp_q.push_back(64'h0000_0002_0000_000E);
    exp_q.push_back(64'h0000_0001_0000_014D);
    @(negedge clock);
    opera2 = 64'd100; opera1 = 32'd7; start = 1'b1;
    @(posedge clock); @(negedge clock);
    opera2 = 64'd1000; opera1 = 32'd3;
    while (edge_n < 80) begin
      if (valid) begin
        if (nv < 2) v_edge[nv] = edge_n;
        nv++;
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
        tests_run++;
        if (result !== exp_v) begin
          tests_failed++;
          $display("FAIL b2b result[%0d] got %h required %h", nv, result, exp_v);
        end
      end
      if (edge_n == 36) start = 1'b0;
      @(posedge clock); edge_n++; @(negedge clock);
    end
    tests_run++;
    if (nv != 2 || v_edge[0] != 34 || v_edge[1] != 68) begin
      tests_failed++;
      $display("FAIL b2b timing got %0d valids at edges %0d,%0d required 2 at 34,68", nv, v_edge[0], v_edge[1]);
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_signed_basic();
    test_div_by_zero();
    test_overflow();
    test_reset_mid_op();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
